// File: rtl/ahb_gpio_bank_if.sv
// Bus-side signal bundle for the h2h AHB-Lite GPIO slave.
// The master drives the address/data phase; the slave answers with ready/resp/rdata.
interface ahb_gpio_bank_if;
    logic        h2h_hsel;
    logic [7:0]  h2h_haddr;
    logic [1:0]  h2h_htrans;
    logic        h2h_hwrite;
    logic [2:0]  h2h_hsize;
    logic [31:0] h2h_hwdata;
    logic        h2h_hready;
    logic        h2h_hreadyout;
    logic        h2h_hresp;
    logic [31:0] h2h_hrdata;

    modport master (
        output h2h_hsel, h2h_haddr, h2h_htrans, h2h_hwrite,
        output h2h_hsize, h2h_hwdata, h2h_hready,
        input  h2h_hreadyout, h2h_hresp, h2h_hrdata
    );

    modport slave (
        input  h2h_hsel, h2h_haddr, h2h_htrans, h2h_hwrite,
        input  h2h_hsize, h2h_hwdata, h2h_hready,
        output h2h_hreadyout, h2h_hresp, h2h_hrdata
    );
endinterface

// File: rtl/ahb_gpio_bank.sv
// Register-mapped GPIO bank on the h2h AHB-Lite bus with per-bit
// output enable, input synchroniser and level/edge interrupt.
module ahb_gpio_bank #(
    parameter int NUM_GPIO    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                h2h_mclk,
    input  logic                h2h_rst,
    ahb_gpio_bank_if.slave      bus,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oe_n,
    output logic                gpio_irq
);
    localparam int N = NUM_GPIO;

    localparam logic [5:0] A_DOUT  = 6'd0;
    localparam logic [5:0] A_OE    = 6'd1;
    localparam logic [5:0] A_DIN   = 6'd2;
    localparam logic [5:0] A_IEN   = 6'd3;
    localparam logic [5:0] A_ITYPE = 6'd4;
    localparam logic [5:0] A_IPOL  = 6'd5;
    localparam logic [5:0] A_ISTAT = 6'd6;
    localparam logic [5:0] A_SET   = 6'd7;
    localparam logic [5:0] A_CLR   = 6'd8;

    typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_e;
    state_e state_q, state_d;

    logic       accept, legal;
    logic       dph_q, wr_q;
    logic [5:0] addr_q;

    logic [N-1:0] dout_q, dout_d, oe_q, oe_d, ien_q, ien_d;
    logic [N-1:0] itype_q, itype_d, ipol_q, ipol_d, est_q, est_d;
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] sync_in, prev_q, rise, fall, hit, level, status;
    logic [N-1:0] wdata, w1c, rmux;
    logic         wen, irq_q;

    assign accept = bus.h2h_hsel & bus.h2h_hready & bus.h2h_htrans[1];
    assign legal  = (bus.h2h_hsize == 3'b010) && (bus.h2h_haddr[7:2] <= A_CLR);

    always_ff @(posedge h2h_mclk) begin
        if (h2h_rst) begin
            state_q <= IDLE;
            dph_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            dph_q   <= accept & legal;
            if (accept) begin
                wr_q   <= bus.h2h_hwrite;
                addr_q <= bus.h2h_haddr[7:2];
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        bus.h2h_hreadyout = 1'b1;
        bus.h2h_hresp     = 1'b0;
        unique case (state_q)
            IDLE: if (accept && !legal) state_d = ERR1;
            ERR1: begin
                bus.h2h_hreadyout = 1'b0;
                bus.h2h_hresp     = 1'b1;
                state_d           = ERR2;
            end
            ERR2: begin
                bus.h2h_hresp = 1'b1;
                state_d       = (accept && !legal) ? ERR1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wen   = dph_q & wr_q;
    assign wdata = bus.h2h_hwdata[N-1:0];

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev_q;
    assign fall    = ~sync_in & prev_q;
    assign hit     = ien_q & itype_q & ((ipol_q & rise) | (~ipol_q & fall));
    assign level   = ien_q & ~itype_q & ~(sync_in ^ ipol_q);
    assign status  = (itype_q & est_q) | level;
    assign w1c     = (wen && addr_q == A_ISTAT) ? wdata : '0;

    always_comb begin
        dout_d  = dout_q;
        oe_d    = oe_q;
        ien_d   = ien_q;
        itype_d = itype_q;
        ipol_d  = ipol_q;
        if (wen) begin
            case (addr_q)
                A_DOUT:  dout_d  = wdata;
                A_OE:    oe_d    = wdata;
                A_IEN:   ien_d   = wdata;
                A_ITYPE: itype_d = wdata;
                A_IPOL:  ipol_d  = wdata;
                A_SET:   dout_d  = dout_q | wdata;
                A_CLR:   dout_d  = dout_q & ~wdata;
                default: ;
            endcase
        end
        // a new edge outranks a simultaneous W1C on the same bit
        est_d = (est_q & ~w1c) | hit;
    end

    always_ff @(posedge h2h_mclk) begin
        if (h2h_rst) begin
            dout_q  <= '0;
            oe_q    <= '0;
            ien_q   <= '0;
            itype_q <= '0;
            ipol_q  <= '0;
            est_q   <= '0;
            prev_q  <= '0;
            irq_q   <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            ien_q   <= ien_d;
            itype_q <= itype_d;
            ipol_q  <= ipol_d;
            est_q   <= est_d;
            prev_q  <= sync_in;
            irq_q   <= |(status & ien_q);
            sync_q[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    always_comb begin
        rmux = '0;
        case (addr_q)
            A_DOUT:  rmux = dout_q;
            A_OE:    rmux = oe_q;
            A_DIN:   rmux = sync_in;
            A_IEN:   rmux = ien_q;
            A_ITYPE: rmux = itype_q;
            A_IPOL:  rmux = ipol_q;
            A_ISTAT: rmux = status;
            default: rmux = '0;
        endcase
        bus.h2h_hrdata = '0;
        if (dph_q && !wr_q) bus.h2h_hrdata[N-1:0] = rmux;
    end

    assign gpio_out  = dout_q;
    assign gpio_oe_n = ~oe_q;
    assign gpio_irq  = irq_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.h2h_hwdata, bus.h2h_haddr[1:0], bus.h2h_htrans[0]};
endmodule

// File: tb/tb_ahb_gpio_bank.sv
// Directed bench for ahb_gpio_bank: register table plus
// hand-built interrupt, error and reset sequences.
module tb_ahb_gpio_bank;
    bit clk = 1'b0;
    logic rst;
    logic [15:0] gpio_in, gpio_out, gpio_oe_n;
    logic gpio_irq;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ahb_gpio_bank_if bus ();
    assign bus.h2h_hready = bus.h2h_hreadyout;

    ahb_gpio_bank #(.NUM_GPIO(16), .SYNC_STAGES(2)) dut (
        .h2h_mclk  (clk),
        .h2h_rst   (rst),
        .bus       (bus.slave),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe_n (gpio_oe_n),
        .gpio_irq  (gpio_irq)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [15:0] exp_out;
        logic [15:0] exp_oen;
    } vec_t;

    vec_t vt [24];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.h2h_hsel   = 1'b0;
        bus.h2h_htrans = 2'd0;
        bus.h2h_hwrite = 1'b0;
        bus.h2h_haddr  = 8'h00;
        bus.h2h_hsize  = 3'b010;
    endtask

    task automatic addr_ph(input logic wr, input logic [7:0] a,
                           input logic [2:0] sz);
        bus.h2h_hsel   = 1'b1;
        bus.h2h_htrans = 2'd2;
        bus.h2h_hwrite = wr;
        bus.h2h_haddr  = a;
        bus.h2h_hsize  = sz;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        addr_ph(1'b1, a, 3'b010);
        step();
        idle();
        bus.h2h_hwdata = d;
        step();
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        addr_ph(1'b0, a, 3'b010);
        step();
        idle();
        d = bus.h2h_hrdata;
        step();
    endtask

    task automatic set_vec(input int i, input logic wr, input logic [7:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input logic [15:0] o, input logic [15:0] oen);
        vt[i].wr = wr; vt[i].addr = a; vt[i].wd = wd;
        vt[i].exp_rd = rd; vt[i].exp_out = o; vt[i].exp_oen = oen;
    endtask

    initial begin
        logic [31:0] rd;

        for (int i = 0; i < 9; i++)
            set_vec(i, 1'b0, 8'(i * 4), 0, 0, 16'h0000, 16'hFFFF);
        set_vec(9,  1'b1, 8'h04, 32'h00FF, 0, 16'h0000, 16'hFF00);
        set_vec(10, 1'b1, 8'h00, 32'h00A5, 0, 16'h00A5, 16'hFF00);
        set_vec(11, 1'b0, 8'h04, 0, 32'h00FF, 16'h00A5, 16'hFF00);
        set_vec(12, 1'b0, 8'h00, 0, 32'h00A5, 16'h00A5, 16'hFF00);
        set_vec(13, 1'b1, 8'h1C, 32'h0100, 0, 16'h01A5, 16'hFF00);
        set_vec(14, 1'b1, 8'h20, 32'h0001, 0, 16'h01A4, 16'hFF00);
        set_vec(15, 1'b0, 8'h00, 0, 32'h01A4, 16'h01A4, 16'hFF00);
        set_vec(16, 1'b0, 8'h1C, 0, 0, 16'h01A4, 16'hFF00);
        set_vec(17, 1'b0, 8'h20, 0, 0, 16'h01A4, 16'hFF00);
        set_vec(18, 1'b1, 8'h08, 32'hFFFF, 0, 16'h01A4, 16'hFF00);
        set_vec(19, 1'b0, 8'h08, 0, 0, 16'h01A4, 16'hFF00);
        set_vec(20, 1'b1, 8'h10, 32'hFFFFFFFF, 0, 16'h01A4, 16'hFF00);
        set_vec(21, 1'b0, 8'h10, 0, 32'h0000FFFF, 16'h01A4, 16'hFF00);
        set_vec(22, 1'b1, 8'h10, 32'h0, 0, 16'h01A4, 16'hFF00);
        set_vec(23, 1'b0, 8'h14, 0, 0, 16'h01A4, 16'hFF00);

        idle();
        bus.h2h_hwdata = '0;
        gpio_in = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_oen", 32'(gpio_oe_n), 32'hFFFF);
        check("rst_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(gpio_irq), 32'h0);
        check("rst_rdy", 32'(bus.h2h_hreadyout), 32'h1);
        check("rst_resp", 32'(bus.h2h_hresp), 32'h0);
        check("rst_rdata", bus.h2h_hrdata, 32'h0);

        for (int i = 0; i < 24; i++) begin
            if (vt[i].wr) begin
                bus_write(vt[i].addr, vt[i].wd);
            end else begin
                bus_read(vt[i].addr, rd);
                check($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
            end
            check($sformatf("vec%0d_out", i), 32'(gpio_out), 32'(vt[i].exp_out));
            check($sformatf("vec%0d_oen", i), 32'(gpio_oe_n), 32'(vt[i].exp_oen));
        end

        // back-to-back write then read of INT_EN
        addr_ph(1'b1, 8'h0C, 3'b010);
        step();
        addr_ph(1'b0, 8'h0C, 3'b010);
        bus.h2h_hwdata = 32'hFFFFFFFF;
        step();
        idle();
        check("b2b_rd", bus.h2h_hrdata, 32'h0000FFFF);
        step();
        bus_write(8'h0C, 32'h0);

        // rising-edge interrupt on bit 0
        bus_write(8'h0C, 32'h1);
        bus_write(8'h10, 32'h1);
        bus_write(8'h14, 32'h1);
        gpio_in[0] = 1'b1;
        step();
        check("edge_irq_e1", 32'(gpio_irq), 32'h0);
        addr_ph(1'b0, 8'h08, 3'b010);
        step();
        check("edge_din", bus.h2h_hrdata, 32'h1);
        addr_ph(1'b0, 8'h18, 3'b010);
        step();
        idle();
        check("edge_stat", bus.h2h_hrdata, 32'h1);
        check("edge_irq_e3", 32'(gpio_irq), 32'h0);
        step();
        check("edge_irq_e4", 32'(gpio_irq), 32'h1);
        bus_write(8'h18, 32'h1);
        bus_read(8'h18, rd);
        check("w1c_stat", rd, 32'h0);
        check("w1c_irq", 32'(gpio_irq), 32'h0);

        // W1C landing in the same cycle as a new rising edge
        gpio_in[0] = 1'b0;
        repeat (5) step();
        gpio_in[0] = 1'b1;
        step();
        addr_ph(1'b1, 8'h18, 3'b010);
        step();
        idle();
        bus.h2h_hwdata = 32'h1;
        step();
        bus_read(8'h18, rd);
        check("w1c_race_stat", rd, 32'h1);
        check("w1c_race_irq", 32'(gpio_irq), 32'h1);
        bus_write(8'h18, 32'h1);
        bus_read(8'h18, rd);
        check("w1c_race_clr", rd, 32'h0);

        // active-low level interrupt on bit 3
        bus_write(8'h10, 32'h1);
        bus_write(8'h14, 32'h1);
        bus_write(8'h0C, 32'h9);
        step();
        check("lvl_irq_on", 32'(gpio_irq), 32'h1);
        bus_write(8'h18, 32'h8);
        bus_read(8'h18, rd);
        check("lvl_w1c_stat", rd, 32'h8);
        check("lvl_w1c_irq", 32'(gpio_irq), 32'h1);
        gpio_in[3] = 1'b1;
        repeat (4) step();
        check("lvl_irq_off", 32'(gpio_irq), 32'h0);
        bus_read(8'h18, rd);
        check("lvl_stat_off", rd, 32'h0);

        // illegal read of offset 0x24
        addr_ph(1'b0, 8'h24, 3'b010);
        step();
        idle();
        check("err_rd_rdy1", 32'(bus.h2h_hreadyout), 32'h0);
        check("err_rd_resp1", 32'(bus.h2h_hresp), 32'h1);
        step();
        check("err_rd_rdy2", 32'(bus.h2h_hreadyout), 32'h1);
        check("err_rd_resp2", 32'(bus.h2h_hresp), 32'h1);
        step();
        check("err_rd_resp3", 32'(bus.h2h_hresp), 32'h0);

        // byte write to DATA_OUT must error and change nothing
        addr_ph(1'b1, 8'h00, 3'b000);
        step();
        idle();
        bus.h2h_hwdata = 32'hFFFF;
        check("err_wr_rdy1", 32'(bus.h2h_hreadyout), 32'h0);
        check("err_wr_resp1", 32'(bus.h2h_hresp), 32'h1);
        step();
        check("err_wr_rdy2", 32'(bus.h2h_hreadyout), 32'h1);
        check("err_wr_resp2", 32'(bus.h2h_hresp), 32'h1);
        step();
        bus_read(8'h00, rd);
        check("err_wr_dout", rd, 32'h01A4);
        check("err_wr_pins", 32'(gpio_out), 32'h01A4);

        // reset while the slave sits in the first error cycle
        addr_ph(1'b0, 8'h30, 3'b010);
        step();
        idle();
        check("rst_err_rdy0", 32'(bus.h2h_hreadyout), 32'h0);
        rst = 1'b1;
        step();
        check("rst_err_rdy", 32'(bus.h2h_hreadyout), 32'h1);
        check("rst_err_resp", 32'(bus.h2h_hresp), 32'h0);
        check("rst_err_oen", 32'(gpio_oe_n), 32'hFFFF);
        check("rst_err_out", 32'(gpio_out), 32'h0);
        rst = 1'b0;
        bus_read(8'h04, rd);
        check("rst_err_oe", rd, 32'h0);
        bus_read(8'h0C, rd);
        check("rst_err_ien", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_gpio_bank.md
# ahb_gpio_bank

AHB-Lite slave for the fabric side of the MCU h2h bus. It provides NUM_GPIO general-purpose I/O channels, each with a per-bit output-enable, an input synchroniser, and a configurable level/edge interrupt. It connects directly to the MCU h2h master ports and replaces fixed-width hard-wired GPIO with a parametrised, register-mapped bank that raises a single interrupt line.

## Interface
- NUM_GPIO, 16: number of channels, 1..32. Register bits at or above NUM_GPIO ignore writes and read 0.
- SYNC_STAGES, 2: flip-flop stages on each gpio_in bit, 2..4.
- h2h_mclk  in  1  single clock; every register updates on its rising edge.
- h2h_rst  in  1  synchronous reset, active-high.
- h2h_hsel  in  1  slave select.
- h2h_haddr  in  8  byte address; only [7:2] is decoded.
- h2h_htrans  in  2  transfer type; NONSEQ=2 and SEQ=3 are active.
- h2h_hwrite  in  1  1 = write.
- h2h_hsize  in  3  transfer size; only 3'b010 (word) is legal.
- h2h_hwdata  in  32  write data, valid in the data phase.
- h2h_hready  in  1  bus ready; an address phase is sampled only when it is high.
- h2h_hreadyout  out  1  slave ready.
- h2h_hresp  out  1  0 = OKAY, 1 = ERROR.
- h2h_hrdata  out  32  read data, valid in the data phase.
- gpio_in  in  NUM_GPIO  pad inputs, asynchronous.
- gpio_out  out  NUM_GPIO  pad output values; equals DATA_OUT.
- gpio_oe_n  out  NUM_GPIO  active-low output enable; equals ~OE.
- gpio_irq  out  1  registered, equals |(INT_STATUS & INT_EN).

## Operation
- **Register map** (word offsets):
  - 0x00 DATA_OUT: RW.
  - 0x04 OE: RW, 1 = drive the pad.
  - 0x08 DATA_IN: RO, synchronised pin values.
  - 0x0C INT_EN: RW.
  - 0x10 INT_TYPE: RW, 0 = level, 1 = edge.
  - 0x14 INT_POL: RW, 1 = high/rising, 0 = low/falling.
  - 0x18 INT_STATUS: edge bits are W1C; level bits are read-only.
  - 0x1C OUT_SET: WO, each 1 sets the matching DATA_OUT bit; reads 0.
  - 0x20 OUT_CLR: WO, each 1 clears the matching DATA_OUT bit; reads 0.
- **Reset values:** every register is 0, so gpio_out=0, gpio_oe_n=all 1, gpio_irq=0, h2h_hreadyout=1, h2h_hresp=0, h2h_hrdata=0.
- **Address phase:** a transfer is accepted when hsel & hready & htrans[1]. hwrite, haddr[7:2] and a legality flag are latched.
- **Illegal transfer:** an offset above 0x20, or hsize other than word. Writes to DATA_IN and reads of OUT_SET/OUT_CLR are legal and have no effect.
- **Bus state machine:**
  - IDLE/OKAY → ERR1 when an illegal transfer is accepted.
  - ERR1 drives hreadyout=0, hresp=1, then → ERR2.
  - ERR2 drives hreadyout=1, hresp=1, then → IDLE, or → ERR1 if another illegal transfer is accepted in the same cycle.
  - An illegal write changes no register.
- **Legal transfers** complete with zero wait states. Write data is committed at the end of the data phase. hrdata is a mux of the current register values, selected by the latched address.
- **Input path:** gpio_in → SYNC_STAGES flops → sync_in (this is DATA_IN) → one more flop, prev.
- **Interrupt status, level bits:** INT_STATUS[i] = INT_EN[i] & (sync_in[i] == INT_POL[i]). The value is live, not latched.
- **Interrupt status, edge bits:** INT_STATUS[i] is set when INT_EN[i] is 1 and sync_in/prev show an edge of the selected polarity. It is cleared by a W1C write.
- **Simultaneous set and W1C** on the same bit: the set wins.
- **Spurious edges after reset** are masked because INT_EN resets to 0.
- **Changing INT_TYPE or INT_POL** does not clear latched edge bits.
- **Reset asserted mid-transfer:** the bus state machine returns to IDLE, hreadyout=1 and hresp=0 from the next cycle, and all registers clear.

## Timing
- **Write to pin:** a write data phase in cycle N makes gpio_out/gpio_oe_n change at the clock edge ending cycle N, so the new value is visible in cycle N+1.
- **Read after write:** a read address phase in cycle N paired with a write data phase in cycle N returns the new value in cycle N+1.
- **Pin to DATA_IN:** a gpio_in change is readable SYNC_STAGES cycles later.
- **Pin to status:** an edge status bit sets SYNC_STAGES+1 cycles after the pin change.
- **Status to interrupt:** gpio_irq follows one cycle after the INT_STATUS change.
- **Error response:** always exactly two cycles.

## Test plan
- **Reset:** assert h2h_rst for 2 cycles → gpio_oe_n=16'hFFFF, gpio_out=0, gpio_irq=0; every readable register returns 0.
- **Output path:**
  - Write OE=16'h00FF, then DATA_OUT=16'h00A5 → gpio_oe_n=16'hFF00, gpio_out=16'h00A5.
  - Then OUT_SET=16'h0100 and OUT_CLR=16'h0001 → DATA_OUT reads 16'h01A4.
- **Rising-edge interrupt:**
  - Set INT_EN=1, INT_TYPE=1, INT_POL=1.
  - Raise gpio_in[0] → INT_STATUS[0]=1 after 3 cycles and gpio_irq=1 one cycle later.
  - W1C with 1 → both return to 0.
  - W1C in the same cycle as a new edge → the bit stays 1.
- **Level interrupt:**
  - Set INT_TYPE[3]=0, INT_POL[3]=0, INT_EN[3]=1, and drive gpio_in[3]=0 → gpio_irq=1.
  - A W1C write does not clear it.
  - Drive gpio_in[3]=1 → gpio_irq=0 within SYNC_STAGES+2 cycles.
- **Error response:**
  - Read offset 0x24 → one cycle with hreadyout=0, hresp=1, then one cycle with hreadyout=1, hresp=1.
  - Byte write (hsize=0) to 0x00 → the same two-cycle error, and DATA_OUT is unchanged.
- **Back-to-back and reset mid-error:**
  - Back-to-back NONSEQ write then read of 0x0C with hwdata=32'hFFFFFFFF (NUM_GPIO=16) → the read returns 32'h0000FFFF.
  - Assert reset during ERR1 → hreadyout=1, hresp=0 in the next cycle.
